// File: rtl/inv_round_col_seq.sv
// inv_round_col_seq: AddRoundKey, then stream the state column by column through an external InvMixColumns stage and reassemble the result.
// Optional build macro INV_MX_BYPASS_EN adds i_skip_mix, which lets the final round skip the mix stage.
module inv_round_col_seq #(
  parameter int MX_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_state_in,
  input  logic [127:0] i_round_key,
`ifdef INV_MX_BYPASS_EN
  input  logic         i_skip_mix,
`endif
  output logic [31:0]  o_mx_in,
  input  logic [31:0]  i_mx_out,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_state_out
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t       r_fsm, w_fsm_nxt;
  logic [127:0] r_ark, r_state_out, w_ark_in;
  logic [31:0]  r_mx_in;
  logic [1:0]   r_cnt, w_cnt_nxt, w_cap_col;
  logic         r_out_valid, w_accept, w_skip, w_cap, w_cap_last;
  logic [2:0]   r_tag [MX_LATENCY];
`ifdef INV_MX_BYPASS_EN
  assign w_skip = i_skip_mix;
`else
  assign w_skip = 1'b0;
`endif
  assign o_in_ready  = (r_fsm == IDLE);
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_ark_in    = i_state_in ^ i_round_key;
  assign w_cnt_nxt   = r_cnt + 2'd1;
  // Tag = {valid, column}; it enters when the stage samples mx_in and leaves when mx_out carries that column
  assign w_cap       = r_tag[MX_LATENCY-1][2];
  assign w_cap_col   = r_tag[MX_LATENCY-1][1:0];
  assign w_cap_last  = w_cap & (w_cap_col == 2'd3);
  assign o_mx_in     = r_mx_in;
  assign o_out_valid = r_out_valid;
  assign o_state_out = r_state_out;
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    w_fsm_nxt = w_accept ? (w_skip ? DONE : FEED) : IDLE;
      FEED:    w_fsm_nxt = (r_cnt == 2'd3) ? DRAIN : FEED;
      DRAIN:   w_fsm_nxt = w_cap_last ? DONE : DRAIN;
      DONE:    w_fsm_nxt = i_out_ready ? IDLE : DONE;
      default: w_fsm_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MX_LATENCY; i++) r_tag[i] <= 3'd0;
    end else begin
      r_tag[0] <= {r_fsm == FEED, r_cnt};
      for (int i = 1; i < MX_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ark       <= '0;
      r_cnt       <= '0;
      r_mx_in     <= '0;
      r_state_out <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_cap_last | (w_accept & w_skip) | (r_out_valid & ~i_out_ready);
      if (w_accept) begin
        r_ark <= w_ark_in;
        r_cnt <= 2'd0;
        if (w_skip) r_state_out <= w_ark_in;
        else        r_mx_in     <= w_ark_in[127:96];
      end
      if (r_fsm == FEED && r_cnt != 2'd3) begin
        r_cnt   <= w_cnt_nxt;
        r_mx_in <= r_ark[(3 - int'(w_cnt_nxt))*32 +: 32];
      end
      if (w_cap) r_state_out[(3 - int'(w_cap_col))*32 +: 32] <= i_mx_out;
    end
  end
endmodule
